// File: rtl/mdu_alu_pkg.sv
// Shared ALU operation codes and mul/div FSM state encodings for the multicycle MIPS datapath.
// Codes 0-7 keep their legacy 3-bit values; 8-15 add XOR, shifts and the iterative mul/div ops.
package mdu_alu_pkg;

    localparam logic [3:0] ALU_NOP   = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_NOR   = 4'd7;
    localparam logic [3:0] ALU_XOR   = 4'd8;
    localparam logic [3:0] ALU_SLL   = 4'd9;
    localparam logic [3:0] ALU_SRL   = 4'd10;
    localparam logic [3:0] ALU_SRA   = 4'd11;
    localparam logic [3:0] ALU_MULT  = 4'd12;
    localparam logic [3:0] ALU_MULTU = 4'd13;
    localparam logic [3:0] ALU_DIV   = 4'd14;
    localparam logic [3:0] ALU_DIVU  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    // Mul/div ops occupy the top quarter of the code space.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider producing HI:LO from captured operands.
// Latency: WIDTH cycles from accepted start to done; start is ignored while busy (no backpressure beyond that).
module muldiv_core
    import mdu_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    mdu_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             div_r, neg_q, neg_r, dz;

    logic             accept, last;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept = start && (state != ST_RUN);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    assign a_neg  = op_signed & a[WIDTH-1];
    assign b_neg  = op_signed & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = accept ? ST_RUN : ST_IDLE;
            ST_RUN:           if (last) state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // One iteration step of each algorithm; acc_lo holds multiplier / dividend bits being consumed.
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [WIDTH-1:0]   mul_hi, mul_lo, div_hi, div_lo;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_sh  = {acc_hi, acc_lo[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opnd};
        div_hi  = div_ge ? (div_sh[WIDTH-1:0] - opnd) : div_sh[WIDTH-1:0];
        div_lo  = {acc_lo[WIDTH-2:0], div_ge};
        prod    = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            div_r  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op_div ? a_mag : b_mag;
            opnd   <= op_div ? b_mag : a_mag;
            div_r  <= op_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= op_div && (b == '0);
        end else if (state == ST_RUN) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= div_r ? div_hi : mul_hi;
            acc_lo <= div_r ? div_lo : mul_lo;
            if (last) begin
                // Divide by zero: the restoring loop already leaves the dividend as remainder.
                if (div_r) begin
                    hi <= neg_r ? -div_hi : div_hi;
                    lo <= dz ? '1 : (neg_q ? -div_lo : div_lo);
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/mdu_alu.sv
// Combinational ALU (C/Zero, zero latency) plus an attached iterative mul/div unit writing HI/LO.
// Mul/div takes WIDTH cycles under start/busy/done; starts during busy are dropped, controller stalls on busy.
module mdu_alu
    import mdu_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    logic [SHW-1:0] shamt;
    assign shamt = B[SHW-1:0];

    always_comb begin
        C = A;
        case (ALUOp)
            ALU_NOP:  C = A;
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_SLT:  C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU: C = {{(WIDTH-1){1'b0}}, A < B};
            ALU_NOR:  C = ~(A | B);
            ALU_XOR:  C = A ^ B;
            ALU_SLL:  C = A << shamt;
            ALU_SRL:  C = A >> shamt;
            ALU_SRA:  C = $signed(A) >>> shamt;
            default:  C = A;
        endcase
    end

    assign Zero = (C == '0);

    muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start && is_muldiv(ALUOp)),
        .op_div    (ALUOp[1]),
        .op_signed (~ALUOp[0]),
        .a         (A),
        .b         (B),
        .busy      (busy),
        .done      (done),
        .hi        (HI),
        .lo        (LO)
    );

endmodule

// File: tb/tb_mdu_alu.sv
// Randomised and directed checks of mdu_alu (WIDTH=32) against a plain-arithmetic reference model.
module tb_mdu_alu;
    import mdu_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [3:0]  ALUOp;
    logic [31:0] A, B, C, HI, LO;
    logic        Zero, busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_alu #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .ALUOp(ALUOp),
        .A(A), .B(B), .C(C), .Zero(Zero),
        .HI(HI), .LO(LO), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        int unsigned sh = b % 32;
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return ~(a | b);
            4'd8:    return a ^ b;
            4'd9:    return a << sh;
            4'd10:   return a >> sh;
            4'd11:   return sa >>> sh;
            default: return a;
        endcase
    endfunction

    // Returns {HI, LO}.
    function automatic logic [63:0] mdu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa = a;
        int              sb = b;
        int              q, r;
        case (op)
            4'd12: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            4'd13: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                return up;
            end
            4'd14: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one mul/div op and wait for done; leaves the bench in the done cycle unless then_idle.
    task automatic mdu_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit mid_start, input bit then_idle);
        logic [63:0] exp = mdu_ref(op, a, b);
        int n = 0;
        ALUOp = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_busy", {63'd0, busy}, 64'd1);
        chk("accept_done", {63'd0, done}, 64'd0);
        A = $urandom; B = $urandom;
        #1;
        chk("c_passthru", {32'd0, C}, {32'd0, A});
        while (!done && n < 100) begin
            if (busy) n++;
            start = (mid_start && n == 5);
            if (start) begin
                ALUOp = ALU_DIVU; A = $urandom; B = $urandom;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("latency", n, 32);
        chk("done_hi", {63'd0, done}, 64'd1);
        chk("done_busy", {63'd0, busy}, 64'd0);
        chk("hi", {32'd0, HI}, {32'd0, exp[63:32]});
        chk("lo", {32'd0, LO}, {32'd0, exp[31:0]});
        if (then_idle) begin
            @(posedge clk); #1;
            chk("done_pulse", {63'd0, done}, 64'd0);
            chk("hilo_hold", {HI, LO}, exp);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb, exp_c;
        int          seen;

        rstn = 1'b0; start = 1'b0; ALUOp = ALU_NOP; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, HI}, 64'd0);
        chk("rst_lo", {32'd0, LO}, 64'd0);
        rstn = 1'b1;

        ALUOp = ALU_SUB; A = 32'd5; B = 32'd5; #1;
        chk("sub_c", {32'd0, C}, 64'd0);
        chk("sub_zero", {63'd0, Zero}, 64'd1);
        ALUOp = ALU_SRA; A = 32'h8000_0000; B = 32'd4; #1;
        chk("sra_c", {32'd0, C}, 64'h0000_0000_F800_0000);
        chk("sra_zero", {63'd0, Zero}, 64'd0);
        ALUOp = ALU_SLTU; A = 32'hFFFF_FFFF; B = 32'd1; #1;
        chk("sltu_c", {32'd0, C}, 64'd0);

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            if ($urandom_range(0, 9) == 0) ra = 32'd0;
            ALUOp = op; A = ra; B = rb; #1;
            exp_c = alu_ref(op, ra, rb);
            chk($sformatf("alu_c_op%0d", op), {32'd0, C}, {32'd0, exp_c});
            chk($sformatf("alu_z_op%0d", op), {63'd0, Zero}, {63'd0, exp_c == 32'd0});
        end
        chk("comb_hilo_untouched", {HI, LO}, 64'd0);
        ALUOp = ALU_NOP;
        @(posedge clk); #1;

        mdu_run(ALU_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0, 1'b1);
        mdu_run(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        mdu_run(ALU_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1);
        mdu_run(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        mdu_run(ALU_DIVU,  32'd5,         32'd0,         1'b1, 1'b1);
        mdu_run(ALU_DIV,   32'hFFFF_FFF6, 32'd0,         1'b0, 1'b1);

        // Reset during a multiply aborts it.
        ALUOp = ALU_MULT; A = 32'd12345; B = 32'd678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0; #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, HI}, 64'd0);
        chk("abort_lo", {32'd0, LO}, 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);

        mdu_run(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        mdu_run(ALU_DIVU, 32'd1000, 32'd7, 1'b0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom_range(12, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            mdu_run(op, ra, rb, 1'b0, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_alu.md
# mdu_alu

Parametrised ALU with an attached iterative multiply/divide unit for the multicycle MIPS datapath. Single-cycle operations (arithmetic, logic, compare, shift) stay combinational on `C`/`Zero` as before. MULT/MULTU/DIV/DIVU run over WIDTH cycles under a start/busy/done handshake and write dedicated HI/LO registers. The controller FSM stalls on `busy` and reads HI/LO for MFHI/MFLO through its own result mux.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width, taken from B[SHW-1:0].
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request for a mul/div operation; sampled only in IDLE or DONE.
- `ALUOp`  in  4  operation code (`ALU_*` defines).
- `A`, `B`  in  WIDTH  signed operands.
- `C`  out  WIDTH  combinational result of single-cycle ops.
- `Zero`  out  1  high when C == 0.
- `HI`, `LO`  out  WIDTH  mul/div result registers.
- `busy`  out  1  high while an iteration is in progress.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated.

## Operation
- Codes 0–7 keep their existing meaning, so 3-bit users are unaffected: NOP 0 (C=A), ADD 1, SUB 2, AND 3, OR 4, SLT 5 (signed), SLTU 6, NOR 7.
- New single-cycle codes:
  - XOR 8.
  - SLL 9: C = A << B[SHW-1:0].
  - SRL 10: logical right shift.
  - SRA 11: arithmetic right shift, sign-filled.
- Mul/div codes: MULT 12, MULTU 13, DIV 14, DIVU 15.
  - C = A and Zero = (A == 0) for these codes, regardless of busy.
- FSM states IDLE, RUN, DONE.
  - IDLE/DONE → RUN when start=1 and ALUOp ∈ {12..15}. The edge captures A, B, the op and the operand signs, and clears the counter.
  - start with any other ALUOp is ignored.
  - RUN: one iteration per cycle. At the WIDTH-th iteration edge, go to DONE, write HI/LO and assert done.
  - DONE → IDLE on the next edge unless a new valid start is accepted.
- start while in RUN is ignored. The operation in flight is not disturbed.
- Multiply: shift-add on operand magnitudes; HI:LO = 2·WIDTH-bit product. Signed products are negated when the operand signs differ.
- Divide: restoring division on magnitudes; LO = quotient, HI = remainder.
  - Signed quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - MIN / −1 gives LO = MIN, HI = 0; the natural result, no trap.
  - Divide by zero, signed or unsigned: HI = A, LO = all ones. This is a special case decided at capture, but it still takes the full latency.
- HI/LO hold their values between operations. Single-cycle ops never modify HI/LO.

## Timing
- Reset (rstn low, asynchronous): state IDLE, counter 0, HI = LO = 0, busy = 0, done = 0. C/Zero are combinational and have no reset value.
- Reset mid-RUN aborts the operation. HI/LO become 0 and no done follows.
- Latency: start accepted at edge 0 → busy high from edge 0 to edge WIDTH (WIDTH cycles) → HI/LO valid and done = 1 in the cycle following edge WIDTH.
- busy and done are never high together.
- Back-to-back: start accepted while in DONE enters RUN directly. done drops and busy rises at the same edge.
- C/Zero have zero latency relative to A, B and ALUOp.

## Structure
- Shared include file `ctrl_encode_def.v`:
  - Widen all `ALU_*` codes to 4 bits, keeping values 0–7.
  - Add ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU.
  - Add the FSM state encodings.
- One sub-module, `muldiv_core`: holds the iteration datapath and counter, with ports start/op/signed flags in and busy/done/hi/lo out.
- `mdu_alu` contains the combinational ALU case plus one `muldiv_core` instance.

## Test plan
- WIDTH=32, combinational checks, no clock dependence:
  - SUB A=5, B=5 → C=0, Zero=1.
  - SRA A=0x80000000, B=4 → C=0xF8000000, Zero=0.
  - SLTU A=−1, B=1 → C=0.
- MULT A=−3, B=7, start pulsed once → busy for 32 cycles, then done for 1 cycle with HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU 5 / 0 → HI=5, LO=0xFFFFFFFF after the full 32-cycle latency. A DIVU start pulsed mid-RUN is ignored and the first result is unchanged.
- Assert rstn low 10 cycles into a MULT → busy=0, done=0, HI=LO=0 immediately, with no done afterwards. Then run one full MULT and confirm the correct result, plus a back-to-back start accepted in the DONE cycle.
